monster_wave_ctrl: RTL and testbench
====================================

// Module: monster_wave_ctrl
// PURPOSE
//  Game-flow sequencer for the monster datapath: owns the stage code driven into all monster instances,
//  admits NUM_SLOTS monster slots one at a time, counts kills from their is_dead flags, and advances
//  title -> levels 1..4 (4 = boss) -> win/lose. Sits between input debounce/collision logic and the monster array.
// PARAMETERS
//  NUM_SLOTS     4    monster instances controlled (1..8)
//  INTRO_CYCLES  100  cycles level banner is shown before monsters spawn
//  SPAWN_GAP     30   cycles between successive slot enables
//  CLEAR_CYCLES  60   cycles after final kill before next level (death animation runs out)
//  LIVES         3    player lives per game (1..7)
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous, active-high reset
//  start        in   1          one-cycle pulse, debounced start button
//  player_hit   in   1          one-cycle pulse, player touched a live monster
//  mon_dead     in   NUM_SLOTS  is_dead flag of each monster instance
//  mon_stage    out  4          stage code to monsters: 1..4 only in PLAY/CLEAR, else 4'h0/4'he/4'hf
//  level        out  4          HUD level number (0 in TITLE)
//  slot_en      out  NUM_SLOTS  slot admitted; gates rendering and enable_weapon_collision per monster
//  lives        out  3          remaining lives
//  score        out  16         saturating score
//  game_state   out  3          FSM state code (HUD / debug)
// BEHAVIOUR
//  Reset: FSM=TITLE, level=0, mon_stage=0, slot_en=0, lives=LIVES, score=0, all counters 0.
//  States: TITLE, INTRO, PLAY, CLEAR, WIN, LOSE. All outputs registered (1-cycle latency from cause).
//  TITLE: mon_stage=0. start -> INTRO, level=1, lives=LIVES, score=0.
//  INTRO: mon_stage=0 (holds monsters in reset), timer counts INTRO_CYCLES then -> PLAY; slot_en=0.
//  PLAY: mon_stage=level. Needed kills K(level): L1=2, L2=3, L3=4, L4=1, each min(K,NUM_SLOTS).
//   slot_en bit 0 set on PLAY entry; bit i+1 set SPAWN_GAP cycles after bit i while i+1<K.
//   Kill = rising edge of mon_dead[i] with slot_en[i]=1; multiple same-cycle kills all counted (popcount).
//   Each kill adds level*10 to score; saturates at 16'hFFFF, never wraps.
//   kills>=K -> CLEAR. player_hit -> lives-1; lives reaching 0 -> LOSE.
//   Same-cycle final kill and fatal hit: LOSE wins. Hit with lives already 0 impossible; ignored.
//  CLEAR: mon_stage held at level so death animations finish; player_hit ignored; after CLEAR_CYCLES:
//   level<4 -> INTRO with level+1, slot_en=0, kill count=0; level==4 -> WIN.
//  WIN: mon_stage=4'he. LOSE: mon_stage=4'hf. slot_en=0. start -> TITLE (score, lives held until next start).
//  start ignored outside TITLE/WIN/LOSE; player_hit ignored outside PLAY.
//  mon_dead edge detector registers previous value; cleared to 0 whenever mon_stage is 0/e/f so a
//   stale dead flag never counts in the next level.
//  rst asserted mid-game: immediate return to reset values next edge, no partial kill/score update.
// STRUCTURE
//  Shared package: stage codes (STG_TITLE=4'h0, STG_L1..STG_BOSS=4'h1..4'h4, STG_WIN=4'he,
//   STG_LOSE=4'hf), FSM state enum, per-level kill-target function; monster module uses same codes.
//  Sub-module kill_detect: registered edge detect on mon_dead & slot_en + popcount -> kill count/cycle.
//  Top: FSM, shared timer (intro/spawn/clear), slot shift mask, lives, saturating score.
// TESTING  (sim with INTRO_CYCLES=4, SPAWN_GAP=3, CLEAR_CYCLES=5, NUM_SLOTS=4, LIVES=3)
//  Reset then start -> level=1, mon_stage=0 for 4 cycles, then mon_stage=1, slot_en=0001, 3 cycles later 0011, stays 0011.
//  L1: raise mon_dead[0], then [1] -> score=20, CLEAR; 5 cycles later level=2, mon_stage=0, slot_en=0.
//  L3: raise mon_dead[0..3] same cycle with all enabled -> kills=4, score+=120, -> CLEAR in one step.
//  Boss kill at level 4 -> CLEAR -> WIN, mon_stage=4'he; start -> TITLE, mon_stage=0.
//  Three player_hit pulses in PLAY -> lives 2,1,0, LOSE, mon_stage=4'hf; hit during CLEAR leaves lives unchanged.
//  Fatal hit same cycle as final kill -> LOSE; score preset near 16'hFFF0 + kill -> 16'hFFFF; rst mid-PLAY -> all reset values.

Source files
------------

// File: rtl/monster_wave_ctrl_pkg.sv
// monster_wave_ctrl_pkg: stage codes, FSM states and per-level kill targets shared with the monster datapath
package monster_wave_ctrl_pkg;
  localparam logic [3:0] STG_TITLE = 4'h0;
  localparam logic [3:0] STG_L1    = 4'h1;
  localparam logic [3:0] STG_L2    = 4'h2;
  localparam logic [3:0] STG_L3    = 4'h3;
  localparam logic [3:0] STG_BOSS  = 4'h4;
  localparam logic [3:0] STG_WIN   = 4'he;
  localparam logic [3:0] STG_LOSE  = 4'hf;

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_INTRO = 3'd1,
    S_PLAY  = 3'd2,
    S_CLEAR = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_e;

  function automatic logic [3:0] kill_target(input logic [3:0] lvl, input int num_slots);
    int k;
    k = (lvl == STG_L1) ? 2 : (lvl == STG_L2) ? 3 : (lvl == STG_L3) ? 4 : 1;
    return 4'(k < num_slots ? k : num_slots);
  endfunction
endpackage

// File: rtl/monster_wave_ctrl_if.sv
// monster_wave_ctrl_if: game-flow bus between input/collision logic, the sequencer and the monster array
interface monster_wave_ctrl_if #(parameter int NUM_SLOTS = 4);
  logic                 start;
  logic                 player_hit;
  logic [NUM_SLOTS-1:0] mon_dead;
  logic [3:0]           mon_stage;
  logic [3:0]           level;
  logic [NUM_SLOTS-1:0] slot_en;
  logic [2:0]           lives;
  logic [15:0]          score;
  logic [2:0]           game_state;
  modport master (
    input  start, player_hit, mon_dead,
    output mon_stage, level, slot_en, lives, score, game_state
  );
  modport slave (
    output start, player_hit, mon_dead,
    input  mon_stage, level, slot_en, lives, score, game_state
  );
endinterface

// File: rtl/monster_wave_ctrl_kill_detect.sv
// monster_wave_ctrl_kill_detect: rising edges of admitted slots' dead flags, popcounted per cycle
module monster_wave_ctrl_kill_detect #(
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic [NUM_SLOTS-1:0] mon_dead_i,
  input  logic [NUM_SLOTS-1:0] slot_en_i,
  output logic [3:0]           kills_o
);
  logic [NUM_SLOTS-1:0] prev_q;
  logic [NUM_SLOTS-1:0] rise;

  always_ff @(posedge clk)
    prev_q <= (rst || clr_i) ? '0 : mon_dead_i;

  assign rise = mon_dead_i & ~prev_q & slot_en_i;

  always_comb begin
    kills_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      kills_o = kills_o + 4'(rise[i]);
  end
endmodule

// File: rtl/monster_wave_ctrl.sv
// monster_wave_ctrl: title -> levels 1..4 -> win/lose sequencer driving stage code, slot admission, lives and score
module monster_wave_ctrl
  import monster_wave_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int INTRO_CYCLES = 100,
  parameter int SPAWN_GAP    = 30,
  parameter int CLEAR_CYCLES = 60,
  parameter int LIVES        = 3
) (
  input logic                clk,
  input logic                rst,
  monster_wave_ctrl_if.master bus
);
  localparam int TW = 16;
  localparam logic [TW-1:0] T_INTRO = TW'(INTRO_CYCLES - 1);
  localparam logic [TW-1:0] T_SPAWN = TW'(SPAWN_GAP - 1);
  localparam logic [TW-1:0] T_CLEAR = TW'(CLEAR_CYCLES - 1);

  state_e               state_q;
  logic [3:0]           level_q;
  logic [3:0]           stage_q;
  logic [NUM_SLOTS-1:0] slot_q;
  logic [2:0]           lives_q;
  logic [15:0]          score_q;
  logic [TW-1:0]        timer_q;
  logic [3:0]           kills_q;
  logic [3:0]           kill_now;
  logic [3:0]           target;
  logic [4:0]           kills_d;
  logic [16:0]          score_sum;
  logic [15:0]          score_d;
  logic                 slot_open;
  logic                 stage_clr;

  assign stage_clr = (stage_q == STG_TITLE) || (stage_q == STG_WIN) || (stage_q == STG_LOSE);

  monster_wave_ctrl_kill_detect #(.NUM_SLOTS(NUM_SLOTS)) u_kill (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (stage_clr),
    .mon_dead_i (bus.mon_dead),
    .slot_en_i  (slot_q),
    .kills_o    (kill_now)
  );

  always_comb begin
    target    = kill_target(level_q, NUM_SLOTS);
    kills_d   = {1'b0, kills_q} + {1'b0, kill_now};
    score_sum = {1'b0, score_q} + 17'(kill_now) * 17'(level_q) * 17'd10;
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    slot_open = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (i < int'(target) && !slot_q[i]) slot_open = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_TITLE;
      level_q <= '0;
      stage_q <= STG_TITLE;
      slot_q  <= '0;
      lives_q <= 3'(LIVES);
      score_q <= '0;
      timer_q <= '0;
      kills_q <= '0;
    end else begin
      case (state_q)
        S_TITLE: if (bus.start) begin
          state_q <= S_INTRO;
          level_q <= 4'd1;
          lives_q <= 3'(LIVES);
          score_q <= '0;
          timer_q <= '0;
          kills_q <= '0;
        end
        S_INTRO: if (timer_q == T_INTRO) begin
          state_q <= S_PLAY;
          stage_q <= level_q;
          slot_q  <= NUM_SLOTS'(1);
          timer_q <= '0;
        end else timer_q <= timer_q + 1'b1;
        S_PLAY: begin
          score_q <= score_d;
          kills_q <= kills_d[3:0];
          if (bus.player_hit && lives_q != 3'd0) lives_q <= lives_q - 3'd1;
          // a fatal hit outranks a simultaneous level-clearing kill
          if (bus.player_hit && lives_q == 3'd1) begin
            state_q <= S_LOSE;
            stage_q <= STG_LOSE;
            slot_q  <= '0;
          end else if (kills_d >= {1'b0, target}) begin
            state_q <= S_CLEAR;
            timer_q <= '0;
          end else if (slot_open) begin
            if (timer_q == T_SPAWN) begin
              slot_q  <= NUM_SLOTS'({slot_q, 1'b1});
              timer_q <= '0;
            end else timer_q <= timer_q + 1'b1;
          end
        end
        S_CLEAR: if (timer_q == T_CLEAR) begin
          timer_q <= '0;
          slot_q  <= '0;
          if (level_q == STG_BOSS) begin
            state_q <= S_WIN;
            stage_q <= STG_WIN;
          end else begin
            state_q <= S_INTRO;
            stage_q <= STG_TITLE;
            level_q <= level_q + 4'd1;
            kills_q <= '0;
          end
        end else timer_q <= timer_q + 1'b1;
        default: if (bus.start) begin
          state_q <= S_TITLE;
          stage_q <= STG_TITLE;
          level_q <= '0;
          slot_q  <= '0;
        end
      endcase
    end
  end

  assign bus.mon_stage  = stage_q;
  assign bus.level      = level_q;
  assign bus.slot_en    = slot_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.game_state = state_q;
endmodule

// File: tb/tb_monster_wave_ctrl.sv
// tb_monster_wave_ctrl: directed game-flow scenarios with hand-computed expectations
module tb_monster_wave_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  monster_wave_ctrl_if #(.NUM_SLOTS(4)) bus ();

  monster_wave_ctrl #(
    .NUM_SLOTS(4), .INTRO_CYCLES(4), .SPAWN_GAP(3), .CLEAR_CYCLES(5), .LIVES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_hit();
    bus.player_hit = 1'b1;
    @(negedge clk);
    bus.player_hit = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.player_hit = 1'b0; bus.mon_dead = 4'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++; if (bus.game_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.game_state); end
    checks++; if (bus.level !== 4'd0 || bus.mon_stage !== 4'h0) begin failures++; $display("FAIL reset_level_stage got=%0h/%0h exp=0/0", bus.level, bus.mon_stage); end
    checks++; if (bus.slot_en !== 4'b0 || bus.lives !== 3'd3 || bus.score !== 16'd0) begin failures++; $display("FAIL reset_slot_lives_score got=%b/%0d/%0d exp=0000/3/0", bus.slot_en, bus.lives, bus.score); end
  endtask

  task automatic test_intro_spawn();
    pulse_start();
    checks++; if (bus.level !== 4'd1 || bus.mon_stage !== 4'h0 || bus.game_state !== 3'd1) begin failures++; $display("FAIL start_intro got=%0d/%0h/%0d exp=1/0/1", bus.level, bus.mon_stage, bus.game_state); end
    tick(3);
    checks++; if (bus.mon_stage !== 4'h0 || bus.slot_en !== 4'b0) begin failures++; $display("FAIL intro_hold got=%0h/%b exp=0/0000", bus.mon_stage, bus.slot_en); end
    tick(1);
    checks++; if (bus.mon_stage !== 4'h1 || bus.slot_en !== 4'b0001 || bus.game_state !== 3'd2) begin failures++; $display("FAIL play_entry got=%0h/%b/%0d exp=1/0001/2", bus.mon_stage, bus.slot_en, bus.game_state); end
    tick(2);
    checks++; if (bus.slot_en !== 4'b0001) begin failures++; $display("FAIL spawn_early got=%b exp=0001", bus.slot_en); end
    tick(1);
    checks++; if (bus.slot_en !== 4'b0011) begin failures++; $display("FAIL spawn_gap got=%b exp=0011", bus.slot_en); end
    tick(6);
    checks++; if (bus.slot_en !== 4'b0011) begin failures++; $display("FAIL spawn_limit got=%b exp=0011", bus.slot_en); end
  endtask

  task automatic test_level1_clear();
    bus.mon_dead = 4'b0001;
    tick(1);
    checks++; if (bus.score !== 16'd10 || bus.game_state !== 3'd2) begin failures++; $display("FAIL l1_kill1 got=%0d/%0d exp=10/2", bus.score, bus.game_state); end
    bus.mon_dead = 4'b0011;
    tick(1);
    checks++; if (bus.score !== 16'd20 || bus.game_state !== 3'd3) begin failures++; $display("FAIL l1_clear got=%0d/%0d exp=20/3", bus.score, bus.game_state); end
    bus.mon_dead = 4'b0;
    pulse_hit();
    tick(3);
    checks++; if (bus.game_state !== 3'd3 || bus.mon_stage !== 4'h1 || bus.lives !== 3'd3) begin failures++; $display("FAIL clear_hold got=%0d/%0h/%0d exp=3/1/3", bus.game_state, bus.mon_stage, bus.lives); end
    tick(1);
    checks++; if (bus.level !== 4'd2 || bus.mon_stage !== 4'h0 || bus.slot_en !== 4'b0 || bus.game_state !== 3'd1) begin failures++; $display("FAIL l2_intro got=%0d/%0h/%b/%0d exp=2/0/0000/1", bus.level, bus.mon_stage, bus.slot_en, bus.game_state); end
  endtask

  task automatic test_levels_to_win();
    tick(4);
    checks++; if (bus.mon_stage !== 4'h2) begin failures++; $display("FAIL l2_stage got=%0h exp=2", bus.mon_stage); end
    for (int k = 0; k < 3; k++) begin
      bus.mon_dead = 4'b0001; tick(1);
      bus.mon_dead = 4'b0000; tick(1);
    end
    checks++; if (bus.score !== 16'd80 || bus.game_state !== 3'd3) begin failures++; $display("FAIL l2_clear got=%0d/%0d exp=80/3", bus.score, bus.game_state); end
    tick(5);
    tick(4);
    checks++; if (bus.level !== 4'd3 || bus.mon_stage !== 4'h3) begin failures++; $display("FAIL l3_play got=%0d/%0h exp=3/3", bus.level, bus.mon_stage); end
    tick(9);
    checks++; if (bus.slot_en !== 4'b1111) begin failures++; $display("FAIL l3_slots got=%b exp=1111", bus.slot_en); end
    bus.mon_dead = 4'b1111;
    tick(1);
    checks++; if (bus.score !== 16'd200 || bus.game_state !== 3'd3) begin failures++; $display("FAIL l3_multi got=%0d/%0d exp=200/3", bus.score, bus.game_state); end
    bus.mon_dead = 4'b0;
    tick(5);
    tick(4);
    checks++; if (bus.mon_stage !== 4'h4 || bus.slot_en !== 4'b0001) begin failures++; $display("FAIL boss_play got=%0h/%b exp=4/0001", bus.mon_stage, bus.slot_en); end
    bus.mon_dead = 4'b0001;
    tick(1);
    checks++; if (bus.score !== 16'd240 || bus.game_state !== 3'd3) begin failures++; $display("FAIL boss_kill got=%0d/%0d exp=240/3", bus.score, bus.game_state); end
    bus.mon_dead = 4'b0;
    tick(5);
    checks++; if (bus.game_state !== 3'd4 || bus.mon_stage !== 4'he || bus.slot_en !== 4'b0) begin failures++; $display("FAIL win got=%0d/%0h/%b exp=4/e/0000", bus.game_state, bus.mon_stage, bus.slot_en); end
    pulse_start();
    checks++; if (bus.game_state !== 3'd0 || bus.mon_stage !== 4'h0 || bus.level !== 4'd0 || bus.score !== 16'd240) begin failures++; $display("FAIL win_title got=%0d/%0h/%0d/%0d exp=0/0/0/240", bus.game_state, bus.mon_stage, bus.level, bus.score); end
  endtask

  task automatic test_lose();
    pulse_start();
    checks++; if (bus.score !== 16'd0 || bus.lives !== 3'd3) begin failures++; $display("FAIL restart got=%0d/%0d exp=0/3", bus.score, bus.lives); end
    tick(4);
    pulse_hit();
    checks++; if (bus.lives !== 3'd2) begin failures++; $display("FAIL hit1 got=%0d exp=2", bus.lives); end
    pulse_hit();
    checks++; if (bus.lives !== 3'd1 || bus.game_state !== 3'd2) begin failures++; $display("FAIL hit2 got=%0d/%0d exp=1/2", bus.lives, bus.game_state); end
    pulse_hit();
    checks++; if (bus.lives !== 3'd0 || bus.game_state !== 3'd5 || bus.mon_stage !== 4'hf || bus.slot_en !== 4'b0) begin failures++; $display("FAIL lose got=%0d/%0d/%0h/%b exp=0/5/f/0000", bus.lives, bus.game_state, bus.mon_stage, bus.slot_en); end
    pulse_start();
    checks++; if (bus.game_state !== 3'd0 || bus.lives !== 3'd0) begin failures++; $display("FAIL lose_title got=%0d/%0d exp=0/0", bus.game_state, bus.lives); end
  endtask

  task automatic test_fatal_kill();
    pulse_start();
    tick(4);
    pulse_hit();
    pulse_hit();
    tick(1);
    bus.mon_dead = 4'b0001;
    tick(1);
    bus.mon_dead = 4'b0011;
    bus.player_hit = 1'b1;
    tick(1);
    bus.player_hit = 1'b0;
    bus.mon_dead = 4'b0;
    checks++; if (bus.game_state !== 3'd5 || bus.mon_stage !== 4'hf || bus.lives !== 3'd0) begin failures++; $display("FAIL fatal_vs_kill got=%0d/%0h/%0d exp=5/f/0", bus.game_state, bus.mon_stage, bus.lives); end
    pulse_start();
  endtask

  task automatic test_saturate_and_rst();
    pulse_start();
    tick(4);
    tick(3);
    force dut.score_q = 16'hFFF0;
    #1;
    release dut.score_q;
    bus.mon_dead = 4'b0011;
    tick(1);
    checks++; if (bus.score !== 16'hFFFF || bus.game_state !== 3'd3) begin failures++; $display("FAIL saturate got=%0h/%0d exp=ffff/3", bus.score, bus.game_state); end
    bus.mon_dead = 4'b0;
    tick(5);
    tick(4);
    checks++; if (bus.game_state !== 3'd2 || bus.mon_stage !== 4'h2 || bus.score !== 16'hFFFF) begin failures++; $display("FAIL pre_rst got=%0d/%0h/%0h exp=2/2/ffff", bus.game_state, bus.mon_stage, bus.score); end
    bus.mon_dead = 4'b0001;
    bus.player_hit = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.mon_dead = 4'b0;
    bus.player_hit = 1'b0;
    checks++; if (bus.game_state !== 3'd0 || bus.level !== 4'd0 || bus.mon_stage !== 4'h0 || bus.slot_en !== 4'b0) begin failures++; $display("FAIL rst_mid_fsm got=%0d/%0d/%0h/%b exp=0/0/0/0000", bus.game_state, bus.level, bus.mon_stage, bus.slot_en); end
    checks++; if (bus.score !== 16'd0 || bus.lives !== 3'd3) begin failures++; $display("FAIL rst_mid_score got=%0h/%0d exp=0/3", bus.score, bus.lives); end
  endtask

  initial begin
    test_reset();
    test_intro_spawn();
    test_level1_clear();
    test_levels_to_win();
    test_lose();
    test_fatal_kill();
    test_saturate_and_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
